breakout_game_ctrl: RTL and testbench
=====================================

# breakout_game_ctrl

Game-flow sequencer for the Breakout ball datapath. It owns the match state machine (idle, serve, play, ball lost, game over), lives, score and ball speed, and drives the ball block's animate, re-initialise and speed-configuration inputs. It consumes hit and loss event pulses produced by the ball/paddle collision logic. It sits between the debounced button/mode inputs and the ball block, one instance per playfield.

## Interface
- LIVES, 3: balls per game, 1–3
- SERVE_FRAMES, 60: frame strobes the ball is held at serve position before play, 1–255
- LOST_FRAMES, 90: frame strobes of pause after a lost ball, 1–255
- HITS_PER_SPEED, 4: paddle hits per speed step, 1–15
- INIT_SPEED, 1: speed at game start, 1–15
- MAX_SPEED, 10: speed ceiling, INIT_SPEED–15

Ports:
- i_clk  in  1  base clock
- i_rst  in  1  reset, asynchronous, active-high
- i_ani_stb  in  1  one-cycle frame strobe
- i_mode  in  1  game mode selected; low forces IDLE
- i_start  in  1  debounced start button, one-cycle pulse
- i_paddle_hit  in  1  one-cycle pulse, ball bounced off paddle
- i_ball_lost  in  1  one-cycle pulse, ball reached bottom edge
- o_state  out  3  0 IDLE, 1 SERVE, 2 PLAY, 3 LOST, 4 OVER
- o_animate  out  1  ball may move (high only in PLAY)
- o_ball_rst  out  1  hold ball at initial position/direction (high in IDLE, SERVE, LOST, OVER)
- o_speed  out  4  per-frame increment applied to ball x and y
- o_lives  out  2  remaining balls
- o_score  out  9  paddle hits this game, saturating
- o_endgame  out  1  high in OVER

## Operation
- All outputs are registered. Reset values: o_state=IDLE, o_animate=0, o_ball_rst=1, o_speed=INIT_SPEED, o_lives=LIVES, o_score=0, o_endgame=0. Internal frame counter (8 b) and hit counter (4 b) reset to 0.
- IDLE: when i_start & i_mode, load lives=LIVES, score=0, speed=INIT_SPEED, hit counter=0, frame counter=0; go to SERVE.
- SERVE: on each i_ani_stb, increment the frame counter. The strobe that makes the count equal SERVE_FRAMES moves the FSM to PLAY and clears the counter.
- PLAY: o_animate=1, o_ball_rst=0.
  - On i_paddle_hit: score+1, saturating at 511. Hit counter+1; when it reaches HITS_PER_SPEED, it clears and speed+1, saturating at MAX_SPEED.
  - On i_ball_lost: lives-1, clear the frame counter, go to LOST.
- LOST: count i_ani_stb as in SERVE. At LOST_FRAMES, go to OVER if lives==0, otherwise go to SERVE. Speed drops back to INIT_SPEED and the hit counter clears on re-serve. Score is retained.
- OVER: o_endgame=1. On i_start & i_mode, perform the same load as IDLE and go to SERVE.
- Priority when events coincide:
  1. i_mode low has top priority in any state: go to IDLE next cycle. Lives, score and speed keep their values until the next start. The frame counter clears.
  2. i_ball_lost and i_paddle_hit in the same PLAY cycle: the loss is taken and the hit is ignored (no score).
- Event pulses outside PLAY are ignored.
- i_start outside IDLE/OVER is ignored.
- i_rst asserted mid-game returns immediately to the reset values. No event is remembered.

## Timing
- State changes and counter updates happen at the i_clk edge that samples the qualifying input. Outputs reflect the new state on the following cycle (1-cycle latency).
- Serve delay: PLAY is entered at the edge of the SERVE_FRAMES-th strobe after SERVE entry. A strobe in the same cycle that SERVE is entered is not counted.
- o_animate rises in the same cycle o_state becomes PLAY, and falls in the same cycle o_state becomes LOST.
- i_ani_stb and event pulses must be synchronous to i_clk. Pulses longer than one cycle count once per high cycle.

## Test plan
- Reset, then i_mode=1 and an i_start pulse -> o_state=1, o_lives=3, o_score=0, o_speed=1. After 60 strobes -> o_state=2, o_animate=1.
- In PLAY, 9 i_paddle_hit pulses -> o_score=9, o_speed=3. Then 40 more -> o_speed saturates at 10, o_score=49.
- i_ball_lost -> o_state=3, o_lives=2, o_animate=0. After 90 strobes -> o_state=1, o_speed=1, o_score unchanged.
- Three losses -> after the third LOST delay, o_state=4, o_endgame=1, o_lives=0. An i_start pulse -> o_state=1, o_lives=3, o_score=0.
- i_ball_lost and i_paddle_hit in the same cycle with score=5 -> score stays 5 and o_state=3. i_mode dropped in PLAY -> o_state=0 next cycle, o_ball_rst=1.
- i_rst pulsed during LOST -> all outputs at reset values while i_rst is high, regardless of clock.

Source files
------------

// File: rtl/breakout_game_ctrl.sv
// ---------------------------------------------------------------------------
// breakout_game_ctrl
// Game-flow sequencer for the Breakout ball datapath. Tracks the match state
// (idle, serve, play, ball lost, game over), lives, score and ball speed, and
// drives the animate / re-initialise / speed inputs of the ball block.
//
// Ports:
//   i_clk         base clock
//   i_rst         asynchronous active-high reset
//   i_ani_stb     one-cycle frame strobe
//   i_mode        game mode selected; low forces IDLE
//   i_start       start button pulse (honoured in IDLE and OVER)
//   i_paddle_hit  paddle bounce pulse (honoured in PLAY)
//   i_ball_lost   ball-lost pulse (honoured in PLAY)
//   o_state       0 IDLE, 1 SERVE, 2 PLAY, 3 LOST, 4 OVER
//   o_animate     ball may move (PLAY only)
//   o_ball_rst    hold ball at its initial position (all states except PLAY)
//   o_speed       per-frame ball increment
//   o_lives       remaining balls
//   o_score       paddle hits this game, saturating at 511
//   o_endgame     high in OVER
// ---------------------------------------------------------------------------
module breakout_game_ctrl #(
  parameter int LIVES          = 3,
  parameter int SERVE_FRAMES   = 60,
  parameter int LOST_FRAMES    = 90,
  parameter int HITS_PER_SPEED = 4,
  parameter int INIT_SPEED     = 1,
  parameter int MAX_SPEED      = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ani_stb,
  input  logic       i_mode,
  input  logic       i_start,
  input  logic       i_paddle_hit,
  input  logic       i_ball_lost,
  output logic [2:0] o_state,
  output logic       o_animate,
  output logic       o_ball_rst,
  output logic [3:0] o_speed,
  output logic [1:0] o_lives,
  output logic [8:0] o_score,
  output logic       o_endgame
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_LOST  = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [7:0] SERVE_LIM  = 8'(SERVE_FRAMES);
  localparam logic [7:0] LOST_LIM   = 8'(LOST_FRAMES);
  localparam logic [3:0] HIT_LIM    = 4'(HITS_PER_SPEED);
  localparam logic [3:0] SPEED_INIT = 4'(INIT_SPEED);
  localparam logic [3:0] SPEED_MAX  = 4'(MAX_SPEED);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [8:0] SCORE_MAX  = 9'd511;

  logic [2:0] r_state;
  logic [7:0] r_frame_cnt;
  logic [3:0] r_hit_cnt;
  logic [1:0] r_lives;
  logic [8:0] r_score;
  logic [3:0] r_speed;
  logic       r_animate;
  logic       r_ball_rst;
  logic       r_endgame;

  logic [2:0] w_state_nx;
  logic [7:0] w_frame_nx;
  logic [3:0] w_hit_nx;
  logic [1:0] w_lives_nx;
  logic [8:0] w_score_nx;
  logic [3:0] w_speed_nx;
  logic [7:0] w_frame_inc;
  logic [3:0] w_hit_inc;

  assign w_frame_inc = r_frame_cnt + 8'd1;
  assign w_hit_inc   = r_hit_cnt + 4'd1;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nx = r_state;
    w_frame_nx = r_frame_cnt;
    w_hit_nx   = r_hit_cnt;
    w_lives_nx = r_lives;
    w_score_nx = r_score;
    w_speed_nx = r_speed;

    if (!i_mode) begin
      // Mode drop wins over everything; game values are kept until restart.
      w_state_nx = ST_IDLE;
      w_frame_nx = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (i_start) begin
            w_state_nx = ST_SERVE;
            w_lives_nx = LIVES_INIT;
            w_score_nx = '0;
            w_speed_nx = SPEED_INIT;
            w_hit_nx   = '0;
            w_frame_nx = '0;
          end
        end
        ST_SERVE: begin
          if (i_ani_stb) begin
            if (w_frame_inc == SERVE_LIM) begin
              w_state_nx = ST_PLAY;
              w_frame_nx = '0;
            end else begin
              w_frame_nx = w_frame_inc;
            end
          end
        end
        ST_PLAY: begin
          // A loss in the same cycle as a hit swallows the hit.
          if (i_ball_lost) begin
            w_state_nx = ST_LOST;
            w_lives_nx = r_lives - 2'd1;
            w_frame_nx = '0;
          end else if (i_paddle_hit) begin
            if (r_score != SCORE_MAX) w_score_nx = r_score + 9'd1;
            if (w_hit_inc == HIT_LIM) begin
              w_hit_nx = '0;
              if (r_speed < SPEED_MAX) w_speed_nx = r_speed + 4'd1;
            end else begin
              w_hit_nx = w_hit_inc;
            end
          end
        end
        ST_LOST: begin
          if (i_ani_stb) begin
            if (w_frame_inc == LOST_LIM) begin
              w_frame_nx = '0;
              if (r_lives == 2'd0) begin
                w_state_nx = ST_OVER;
              end else begin
                w_state_nx = ST_SERVE;
                w_speed_nx = SPEED_INIT;
                w_hit_nx   = '0;
              end
            end else begin
              w_frame_nx = w_frame_inc;
            end
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_frame_nx = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= '0;
      r_hit_cnt   <= '0;
      r_lives     <= LIVES_INIT;
      r_score     <= '0;
      r_speed     <= SPEED_INIT;
      r_animate   <= 1'b0;
      r_ball_rst  <= 1'b1;
      r_endgame   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_frame_cnt <= w_frame_nx;
      r_hit_cnt   <= w_hit_nx;
      r_lives     <= w_lives_nx;
      r_score     <= w_score_nx;
      r_speed     <= w_speed_nx;
      // Decoded from the next state so they change together with o_state.
      r_animate   <= (w_state_nx == ST_PLAY);
      r_ball_rst  <= (w_state_nx != ST_PLAY);
      r_endgame   <= (w_state_nx == ST_OVER);
    end
  end

  assign o_state    = r_state;
  assign o_animate  = r_animate;
  assign o_ball_rst = r_ball_rst;
  assign o_speed    = r_speed;
  assign o_lives    = r_lives;
  assign o_score    = r_score;
  assign o_endgame  = r_endgame;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_breakout_game_ctrl
// Directed bench for breakout_game_ctrl with default parameters. Inputs are
// driven on the falling edge and outputs sampled on the falling edge, so
// each one-cycle pulse is visible in the outputs when the pulse is removed.
// ---------------------------------------------------------------------------
module tb_breakout_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ani_stb = 1'b0;
  logic       mode = 1'b0;
  logic       start = 1'b0;
  logic       paddle_hit = 1'b0;
  logic       ball_lost = 1'b0;
  logic [2:0] state;
  logic       animate;
  logic       ball_rst;
  logic [3:0] speed;
  logic [1:0] lives;
  logic [8:0] score;
  logic       endgame;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  breakout_game_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ani_stb    (ani_stb),
    .i_mode       (mode),
    .i_start      (start),
    .i_paddle_hit (paddle_hit),
    .i_ball_lost  (ball_lost),
    .o_state      (state),
    .o_animate    (animate),
    .o_ball_rst   (ball_rst),
    .o_speed      (speed),
    .o_lives      (lives),
    .o_score      (score),
    .o_endgame    (endgame)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".state"},    16'(state),    16'd0);
    check({tag, ".animate"},  16'(animate),  16'd0);
    check({tag, ".ball_rst"}, 16'(ball_rst), 16'd1);
    check({tag, ".speed"},    16'(speed),    16'd1);
    check({tag, ".lives"},    16'(lives),    16'd3);
    check({tag, ".score"},    16'(score),    16'd0);
    check({tag, ".endgame"},  16'(endgame),  16'd0);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ani_stb = 1'b1;
      @(negedge clk) ani_stb = 1'b0;
    end
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) paddle_hit = 1'b1;
      @(negedge clk) paddle_hit = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_lost();
    @(negedge clk) ball_lost = 1'b1;
    @(negedge clk) ball_lost = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // Start a game
    mode = 1'b1;
    pulse_start();
    check("start.state", 16'(state), 16'd1);
    check("start.lives", 16'(lives), 16'd3);
    check("start.score", 16'(score), 16'd0);
    check("start.speed", 16'(speed), 16'd1);
    check("start.ball_rst", 16'(ball_rst), 16'd1);

    // Start pulse in SERVE is ignored; then serve delay boundary
    pulse_start();
    check("serve_start_ign", 16'(state), 16'd1);
    strobes(59);
    check("serve59.state", 16'(state), 16'd1);
    check("serve59.animate", 16'(animate), 16'd0);
    strobes(1);
    check("serve60.state", 16'(state), 16'd2);
    check("serve60.animate", 16'(animate), 16'd1);
    check("serve60.ball_rst", 16'(ball_rst), 16'd0);

    // Scoring and speed steps
    hits(9);
    check("hit9.score", 16'(score), 16'd9);
    check("hit9.speed", 16'(speed), 16'd3);
    hits(40);
    check("hit49.score", 16'(score), 16'd49);
    check("hit49.speed", 16'(speed), 16'd10);

    // First loss
    pulse_lost();
    check("lost1.state", 16'(state), 16'd3);
    check("lost1.lives", 16'(lives), 16'd2);
    check("lost1.animate", 16'(animate), 16'd0);
    hits(1);
    check("lost_hit_ign", 16'(score), 16'd49);
    strobes(89);
    check("lost89.state", 16'(state), 16'd3);
    strobes(1);
    check("lost90.state", 16'(state), 16'd1);
    check("lost90.speed", 16'(speed), 16'd1);
    check("lost90.score", 16'(score), 16'd49);

    // Second and third loss -> OVER
    strobes(60);
    pulse_lost();
    check("lost2.lives", 16'(lives), 16'd1);
    strobes(90);
    strobes(60);
    pulse_lost();
    check("lost3.lives", 16'(lives), 16'd0);
    strobes(90);
    check("over.state", 16'(state), 16'd4);
    check("over.endgame", 16'(endgame), 16'd1);
    check("over.lives", 16'(lives), 16'd0);
    check("over.ball_rst", 16'(ball_rst), 16'd1);
    check("over.score", 16'(score), 16'd49);
    hits(1);
    check("over_hit_ign", 16'(score), 16'd49);

    // Restart from OVER
    pulse_start();
    check("restart.state", 16'(state), 16'd1);
    check("restart.lives", 16'(lives), 16'd3);
    check("restart.score", 16'(score), 16'd0);
    check("restart.endgame", 16'(endgame), 16'd0);

    // Coincident loss and hit at score 5
    strobes(60);
    hits(5);
    check("pre_coinc.score", 16'(score), 16'd5);
    @(negedge clk) begin ball_lost = 1'b1; paddle_hit = 1'b1; end
    @(negedge clk) begin ball_lost = 1'b0; paddle_hit = 1'b0; end
    check("coinc.score", 16'(score), 16'd5);
    check("coinc.state", 16'(state), 16'd3);
    check("coinc.lives", 16'(lives), 16'd2);

    // Mode drop in PLAY keeps game values
    strobes(90);
    strobes(60);
    hits(4);
    check("pre_mode.speed", 16'(speed), 16'd2);
    @(negedge clk) mode = 1'b0;
    @(negedge clk);
    check("mode_drop.state", 16'(state), 16'd0);
    check("mode_drop.ball_rst", 16'(ball_rst), 16'd1);
    check("mode_drop.animate", 16'(animate), 16'd0);
    check("mode_drop.speed", 16'(speed), 16'd2);
    check("mode_drop.score", 16'(score), 16'd9);
    check("mode_drop.lives", 16'(lives), 16'd2);
    pulse_start();
    check("start_no_mode", 16'(state), 16'd0);

    // Start coincident with a strobe: that strobe is not counted
    mode = 1'b1;
    @(negedge clk) begin start = 1'b1; ani_stb = 1'b1; end
    @(negedge clk) begin start = 1'b0; ani_stb = 1'b0; end
    check("co_strobe.state", 16'(state), 16'd1);
    strobes(59);
    check("co_strobe59.state", 16'(state), 16'd1);
    strobes(1);
    check("co_strobe60.state", 16'(state), 16'd2);

    // Score saturation
    hits(515);
    check("score_sat", 16'(score), 16'd511);
    check("speed_sat", 16'(speed), 16'd10);

    // Asynchronous reset during LOST
    pulse_lost();
    check("pre_rst.state", 16'(state), 16'd3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    repeat (3) @(negedge clk);
    check_reset_vals("rst_held");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.state", 16'(state), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
